// File: rtl/vdp_cpu_io_bridge.sv
// ---------------------------------------------------------------------------
// vdp_cpu_io_bridge
//    Z80 I/O-port front end for the VDP core. Decodes a parametrised port
//    window, synchronises and deglitches the bus strobes, buffers CPU writes
//    in a small FIFO and runs a REQ/ACK handshake into the VDP. Read data
//    coming back from the VDP is held in a register that drives the CPU bus.
//
// Ports
//    clk_w, reset_n_w        clock, asynchronous active-low reset
//    io_addr, iorq_n,        raw Z80 address and strobes
//    rd_n, wr_n
//    cd_in / cd_out / cd_oe  CPU data bus in, read data out, drive enable
//    cs_n                    combinational window hit (active low)
//    vdp_req/wrt/adr/dbo     request to the VDP (level, held until ack)
//    vdp_dbi, vdp_ack        VDP read data and one-cycle acknowledge
//    fifo_level              number of queued writes
//    overflow, timeout       sticky error flags
// ---------------------------------------------------------------------------
module vdp_cpu_io_bridge #(
   parameter logic [7:0] BASE_ADDR   = 8'h98,
   parameter int         PORT_BITS   = 2,
   parameter int         FILTER_LEN  = 3,
   parameter int         FIFO_DEPTH  = 4,
   parameter int         ACK_TIMEOUT = 255,
   localparam int        LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk_w,
   input  logic                 reset_n_w,
   input  logic [7:0]           io_addr,
   input  logic                 iorq_n,
   input  logic                 rd_n,
   input  logic                 wr_n,
   input  logic [7:0]           cd_in,
   output logic [7:0]           cd_out,
   output logic                 cd_oe,
   output logic                 cs_n,
   output logic                 vdp_req,
   output logic                 vdp_wrt,
   output logic [PORT_BITS-1:0] vdp_adr,
   output logic [7:0]           vdp_dbo,
   input  logic [7:0]           vdp_dbi,
   input  logic                 vdp_ack,
   output logic [LVL_W-1:0]     fifo_level,
   output logic                 overflow,
   output logic                 timeout
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int EW = PORT_BITS + 8;
   localparam logic [TW-1:0]    TMO_LAST = TW'(ACK_TIMEOUT - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_RD_DRAIN,
      ST_RD_REQ,
      ST_RD_HOLD
   } state_t;

   // ---------------- combinational decode on the raw pins -----------------
   logic hit;
   assign hit   = (io_addr[7:PORT_BITS] == BASE_ADDR[7:PORT_BITS]) & ~iorq_n;
   assign cs_n  = ~hit;
   assign cd_oe = hit & ~rd_n;

   // ---------------- two-flop synchroniser + aligned addr/data ------------
   // Strobe vector order: [0]=iorq_n, [1]=rd_n, [2]=wr_n.
   logic [2:0] sync1_q, sync2_q;
   logic [7:0] addr1_q, addr2_q, data1_q, data2_q;

   always_ff @(posedge clk_w or negedge reset_n_w) begin
      if (!reset_n_w) begin
         sync1_q <= 3'b111;
         sync2_q <= 3'b111;
         addr1_q <= 8'h00;
         addr2_q <= 8'h00;
         data1_q <= 8'h00;
         data2_q <= 8'h00;
      end else begin
         sync1_q <= {wr_n, rd_n, iorq_n};
         sync2_q <= sync1_q;
         addr1_q <= io_addr;
         addr2_q <= addr1_q;
         data1_q <= cd_in;
         data2_q <= data1_q;
      end
   end

   // ---------------- sample filters ---------------------------------------
   // A filtered strobe only changes after FILTER_LEN consecutive synchronised
   // samples disagree with it. filt_d is the value it takes at the next edge,
   // so edge detection (filt_q vs filt_d) adds no extra cycle of latency.
   logic [2:0] filt_q, filt_d;

   for (genvar gi = 0; gi < 3; gi++) begin : g_filter
      logic [2:0] cnt_q, cnt_d;
      logic       lvl_q, lvl_d;

      always_comb begin
         cnt_d = 3'd0;
         lvl_d = lvl_q;
         if (sync2_q[gi] != lvl_q) begin
            if (cnt_q == 3'(FILTER_LEN - 1)) begin
               lvl_d = sync2_q[gi];
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
      end

      always_ff @(posedge clk_w or negedge reset_n_w) begin
         if (!reset_n_w) begin
            cnt_q <= 3'd0;
            lvl_q <= 1'b1;
         end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
         end
      end

      assign filt_q[gi] = lvl_q;
      assign filt_d[gi] = lvl_d;
   end

   // IORQ counts as active on the cycle its filtered level falls, so a
   // WR/RD strobe that falls together with IORQ still decodes.
   logic                 fhit, wr_fall, rd_fall;
   logic [PORT_BITS-1:0] port_now;
   assign fhit     = (addr2_q[7:PORT_BITS] == BASE_ADDR[7:PORT_BITS]) &
                     ~(filt_q[0] & filt_d[0]);
   assign wr_fall  = filt_q[2] & ~filt_d[2] & fhit;
   assign rd_fall  = filt_q[1] & ~filt_d[1] & fhit;
   assign port_now = addr2_q[PORT_BITS-1:0];

   // ---------------- write FIFO -------------------------------------------
   logic [EW-1:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             full, empty, pop, push_ok;
   logic [EW-1:0]    head;

   assign full    = (level_q == LVL_FULL);
   assign empty   = (level_q == '0);
   // A pop in the same cycle frees the slot, so a push into a full FIFO is
   // still accepted then.
   assign push_ok = wr_fall & (~full | pop);
   assign head    = fifo_mem[rd_ptr_q];

   always_ff @(posedge clk_w) begin
      if (push_ok) begin
         fifo_mem[wr_ptr_q] <= {port_now, data2_q};
      end
   end

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      if (push_ok && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (!push_ok && pop) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   // ---------------- request FSM ------------------------------------------
   state_t               state_q, state_d;
   logic                 rd_pend_q, rd_pend_d, rd_pend_clr;
   logic [PORT_BITS-1:0] rd_port_q, rd_port_d;
   logic [7:0]           rd_data_q, rd_data_d;
   logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
   logic                 gap_q, gap_d;
   logic                 overflow_q, overflow_d, timeout_q, timeout_d;
   logic                 tmo_hit, tmo_set;

   assign tmo_hit = (tmo_cnt_q == TMO_LAST);

   always_comb begin
      state_d     = state_q;
      vdp_req     = 1'b0;
      vdp_wrt     = 1'b0;
      vdp_adr     = '0;
      vdp_dbo     = 8'h00;
      pop         = 1'b0;
      rd_pend_clr = 1'b0;
      rd_data_d   = rd_data_q;
      tmo_set     = 1'b0;
      gap_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A pending read wins, but drains queued writes first.
            if (rd_pend_q) begin
               state_d     = ST_RD_DRAIN;
               rd_pend_clr = 1'b1;
            end else if (!empty) begin
               state_d = ST_WR_REQ;
            end
         end
         ST_WR_REQ: begin
            vdp_req = 1'b1;
            vdp_wrt = 1'b1;
            vdp_adr = head[EW-1:8];
            vdp_dbo = head[7:0];
            if (vdp_ack || tmo_hit) begin
               pop     = 1'b1;
               tmo_set = ~vdp_ack;
               state_d = ST_IDLE;
            end
         end
         ST_RD_DRAIN: begin
            if (empty) begin
               state_d = ST_RD_REQ;
            end else if (!gap_q) begin
               // gap_q forces one idle cycle between back-to-back writes.
               vdp_req = 1'b1;
               vdp_wrt = 1'b1;
               vdp_adr = head[EW-1:8];
               vdp_dbo = head[7:0];
               if (vdp_ack || tmo_hit) begin
                  pop     = 1'b1;
                  tmo_set = ~vdp_ack;
                  gap_d   = 1'b1;
               end
            end
         end
         ST_RD_REQ: begin
            vdp_req = 1'b1;
            vdp_adr = rd_port_q;
            if (vdp_ack) begin
               rd_data_d = vdp_dbi;
               state_d   = ST_RD_HOLD;
            end else if (tmo_hit) begin
               rd_data_d = 8'hFF;
               tmo_set   = 1'b1;
               state_d   = ST_RD_HOLD;
            end
         end
         ST_RD_HOLD: begin
            // One CPU read strobe maps to exactly one VDP read.
            if (filt_q[1]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_pend_d  = rd_fall | (rd_pend_q & ~rd_pend_clr);
      rd_port_d  = rd_fall ? port_now : rd_port_q;
      tmo_cnt_d  = (vdp_req && !vdp_ack && !tmo_hit) ? tmo_cnt_q + TW'(1) : '0;
      overflow_d = overflow_q | (wr_fall & full & ~pop);
      timeout_d  = timeout_q | tmo_set;
   end

   always_ff @(posedge clk_w or negedge reset_n_w) begin
      if (!reset_n_w) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         rd_pend_q  <= 1'b0;
         rd_port_q  <= '0;
         rd_data_q  <= 8'hFF;
         tmo_cnt_q  <= '0;
         gap_q      <= 1'b0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         rd_pend_q  <= rd_pend_d;
         rd_port_q  <= rd_port_d;
         rd_data_q  <= rd_data_d;
         tmo_cnt_q  <= tmo_cnt_d;
         gap_q      <= gap_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
      end
   end

   assign cd_out     = rd_data_q;
   assign fifo_level = level_q;
   assign overflow   = overflow_q;
   assign timeout    = timeout_q;

endmodule
